// File: rtl/uart_tx_ctrl_if.sv
// Byte-push handshake between the bridge/CPU side and the UART transmit engine.
// The producer drives tx_data/tx_valid; the engine returns tx_ready and its queue depth.
interface uart_tx_ctrl_if #(
  parameter int unsigned FIFO_DEPTH = 4
) ();

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [CNT_W-1:0] fifo_count;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  fifo_count
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output fifo_count
  );

endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmit engine: small byte FIFO feeding an 8N1 serializer, LSB first.
// Optional macro UART_TX_PARITY_EN inserts an even-parity bit after the data bits.
// uart_txd comes straight from a flop; back-to-back frames are sent with no idle gap.
module uart_tx_ctrl #(
  parameter int unsigned BAUD_DIV   = 2604,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic          clk_in,
  input  logic          sys_rstn,
  uart_tx_ctrl_if.slave bus,
  output logic          tx_busy,
  output logic          uart_txd
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned BDC_W = $clog2(STOP_BITS * BAUD_DIV);

  localparam logic [BDC_W-1:0] BIT_RELOAD  = BDC_W'(BAUD_DIV - 1);
  localparam logic [BDC_W-1:0] STOP_RELOAD = BDC_W'(STOP_BITS * BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] FULL_COUNT  = CNT_W'(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd4;
`endif

  // FIFO storage and bookkeeping
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] head_q, tail_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop;

  // Serializer state
  logic [2:0]       state_q, state_d;
  logic [BDC_W-1:0] baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             txd_q, txd_d;
  logic             busy_q;
  logic             load;
`ifdef UART_TX_PARITY_EN
  logic             par_q, par_d;
`endif

  assign bus.tx_ready   = (count_q != FULL_COUNT);
  assign bus.fifo_count = count_q;
  assign tx_busy        = busy_q;
  assign uart_txd       = txd_q;

  assign push    = bus.tx_valid && bus.tx_ready;
  assign count_d = count_q + CNT_W'(push) - CNT_W'(pop);

  // FIFO write port; contents are meaningless while count is zero, so no reset
  always_ff @(posedge clk_in) begin
    if (push) begin
      mem[tail_q] <= bus.tx_data;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk_in or negedge sys_rstn) begin
    if (!sys_rstn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        tail_q <= tail_q + PTR_W'(1);
      end
      if (pop) begin
        head_q <= head_q + PTR_W'(1);
      end
      count_q <= count_d;
    end
  end

  // Serializer state register; reset forces the line high at once
  always_ff @(posedge clk_in or negedge sys_rstn) begin
    if (!sys_rstn) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
      busy_q  <= (state_d != S_IDLE);
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Next-state and next-line-level logic; 'load' pops the FIFO head into a new frame
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    txd_d   = txd_q;
    load    = 1'b0;
    pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif

    case (state_q)
      S_IDLE: begin
        txd_d = 1'b1;
        if (count_q != '0) begin
          load = 1'b1;
        end
      end

      S_START: begin
        if (baud_q == '0) begin
          state_d = S_DATA;
          baud_d  = BIT_RELOAD;
          txd_d   = shift_q[0];
        end else begin
          baud_d = baud_q - BDC_W'(1);
        end
      end

      S_DATA: begin
        if (baud_q == '0) begin
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
            baud_d  = BIT_RELOAD;
            txd_d   = par_q;
`else
            state_d = S_STOP;
            baud_d  = STOP_RELOAD;
            txd_d   = 1'b1;
`endif
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            baud_d  = BIT_RELOAD;
            txd_d   = shift_q[1];
          end
        end else begin
          baud_d = baud_q - BDC_W'(1);
        end
      end

`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud_q == '0) begin
          state_d = S_STOP;
          baud_d  = STOP_RELOAD;
          txd_d   = 1'b1;
        end else begin
          baud_d = baud_q - BDC_W'(1);
        end
      end
`endif

      S_STOP: begin
        if (baud_q == '0) begin
          if (count_q != '0) begin
            load = 1'b1;
          end else begin
            state_d = S_IDLE;
            txd_d   = 1'b1;
          end
        end else begin
          baud_d = baud_q - BDC_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        baud_d  = '0;
        txd_d   = 1'b1;
      end
    endcase

    if (load) begin
      pop     = 1'b1;
      shift_d = mem[head_q];
      bit_d   = '0;
      baud_d  = BIT_RELOAD;
      txd_d   = 1'b0;
      state_d = S_START;
`ifdef UART_TX_PARITY_EN
      par_d   = ^mem[head_q];
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: directed timing checks plus randomized traffic,
// with a line-level receiver model that rebuilds bytes from uart_txd.
module tb_uart_tx_ctrl;

  localparam int unsigned BAUD  = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned STOPB = 1;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned PBITS = 1;
`else
  localparam int unsigned PBITS = 0;
`endif
  localparam int unsigned NBITS = 1 + 8 + PBITS + STOPB;
  localparam int unsigned FRAME = NBITS * BAUD;

  logic clk_in   = 1'b0;
  logic sys_rstn = 1'b0;
  logic tx_busy;
  logic uart_txd;

  uart_tx_ctrl_if #(.FIFO_DEPTH(DEPTH)) bus ();

  uart_tx_ctrl #(
    .BAUD_DIV   (BAUD),
    .FIFO_DEPTH (DEPTH),
    .STOP_BITS  (STOPB)
  ) dut (
    .clk_in   (clk_in),
    .sys_rstn (sys_rstn),
    .bus      (bus),
    .tx_busy  (tx_busy),
    .uart_txd (uart_txd)
  );

  always #5 clk_in = ~clk_in;

  int unsigned cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] rx_q [$];
  logic [7:0] exp_q [$];
  int         frame_err  = 0;
  logic       mon_active = 1'b0;
  logic [7:0] mon_b;
  logic       mon_ok;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected line level for frame bit position idx of byte b
  function automatic logic exp_bit(input logic [7:0] b, input int unsigned idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    if (PBITS == 1 && idx == 9) return ^b;
    return 1'b1;
  endfunction

  // Receiver model: mid-bit sampling of uart_txd, pushes decoded bytes
  initial begin
    forever begin
      @(negedge clk_in);
      if (sys_rstn && uart_txd == 1'b0) begin
        mon_active = 1'b1;
        repeat (BAUD / 2) @(negedge clk_in);
        mon_ok = (uart_txd == 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (BAUD) @(negedge clk_in);
          mon_b[i] = uart_txd;
        end
        if (PBITS == 1) begin
          repeat (BAUD) @(negedge clk_in);
          if (uart_txd != ^mon_b) mon_ok = 1'b0;
        end
        for (int s = 0; s < int'(STOPB); s++) begin
          repeat (BAUD) @(negedge clk_in);
          if (uart_txd != 1'b1) mon_ok = 1'b0;
        end
        rx_q.push_back(mon_b);
        if (!mon_ok) frame_err++;
        mon_active = 1'b0;
      end
    end
  end

  // Offer one byte; returns the edge index on which the handshake completed
  task automatic push_byte(input logic [7:0] b, output int unsigned edge_n);
    logic r;
    int   n;
    n = 0;
    bus.tx_data  = b;
    bus.tx_valid = 1'b1;
    do begin
      r = bus.tx_ready;
      @(posedge clk_in);
      #1;
      n++;
    end while (!r && n < 200);
    if (!r) chk_eq("push_timeout", 32'(r), 32'd1);
    edge_n       = cyc;
    bus.tx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((tx_busy || bus.fifo_count != 0 || mon_active) && n < 2000) begin
      @(negedge clk_in);
      n++;
    end
    if (n >= 2000) chk_eq("idle_timeout", 32'(tx_busy), 32'd0);
    repeat (2) @(negedge clk_in);
    rx_q.delete();
    frame_err = 0;
  endtask

  task automatic wait_rx(input int n);
    int k;
    k = 0;
    while (rx_q.size() < n && k < n * int'(FRAME) + 200) begin
      @(negedge clk_in);
      k++;
    end
    chk_eq("rx_count", 32'(rx_q.size()), 32'(n));
  endtask

  task automatic check_rx();
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      chk_eq($sformatf("rx_byte%0d", i), 32'(rx_q[i]), 32'(exp_q[i]));
    end
    chk_eq("frame_err", 32'(frame_err), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned e0, e1, e2;
    int          lows;
    logic [7:0]  b;
    logic [7:0]  burst [5];

    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;

    // Reset state
    repeat (3) @(negedge clk_in);
    chk_eq("rst_txd",   32'(uart_txd),       32'd1);
    chk_eq("rst_ready", 32'(bus.tx_ready),   32'd1);
    chk_eq("rst_busy",  32'(tx_busy),        32'd0);
    chk_eq("rst_count", 32'(bus.fifo_count), 32'd0);
    sys_rstn = 1'b1;
    @(posedge clk_in);
    #1;

    // Single byte in idle: bit-exact waveform
    push_byte(8'hA5, e0);
    @(negedge clk_in);
    chk_eq("a5_count_pre", 32'(bus.fifo_count), 32'd1);
    chk_eq("a5_txd_pre",   32'(uart_txd),       32'd1);
    chk_eq("a5_busy_pre",  32'(tx_busy),        32'd0);
    for (int k = 0; k < int'(FRAME); k++) begin
      @(negedge clk_in);
      chk_eq($sformatf("a5_txd_k%0d", k), 32'(uart_txd), 32'(exp_bit(8'hA5, k / BAUD)));
      chk_eq($sformatf("a5_busy_k%0d", k), 32'(tx_busy), 32'd1);
    end
    @(negedge clk_in);
    chk_eq("a5_busy_end", 32'(tx_busy),  32'd0);
    chk_eq("a5_txd_end",  32'(uart_txd), 32'd1);
    exp_q = '{8'hA5};
    wait_rx(1);
    check_rx();
    wait_idle();

    // Back-to-back burst: fills the FIFO, frames must be contiguous
    burst = '{8'h55, 8'h0F, 8'hF0, 8'h81, 8'h3C};
    push_byte(burst[0], e0);
    for (int i = 1; i < 5; i++) push_byte(burst[i], e1);
    chk_eq("burst_accept_edge", 32'(e1 - e0), 32'd4);
    @(negedge clk_in);
    chk_eq("burst_count_full", 32'(bus.fifo_count), 32'(DEPTH));
    chk_eq("burst_ready_full", 32'(bus.tx_ready),   32'd0);
    while (tx_busy && cyc < e0 + 10 * FRAME) @(negedge clk_in);
    chk_eq("burst_busy_span", 32'(cyc - e0), 32'(1 + 5 * FRAME));
    exp_q = '{8'h55, 8'h0F, 8'hF0, 8'h81, 8'h3C};
    wait_rx(5);
    check_rx();
    wait_idle();

    // Push exactly on the edge a STOP completes, with one byte already queued
    push_byte(8'hC3, e0);
    push_byte(8'h7E, e1);
    while (cyc < e0 + FRAME) begin
      @(posedge clk_in);
      #1;
    end
    push_byte(8'h19, e2);
    chk_eq("stop_push_edge", 32'(e2 - e0), 32'(FRAME + 1));
    @(negedge clk_in);
    chk_eq("stop_push_count", 32'(bus.fifo_count), 32'd1);
    chk_eq("stop_push_txd",   32'(uart_txd),       32'd0);
    chk_eq("stop_push_busy",  32'(tx_busy),        32'd1);
    exp_q = '{8'hC3, 8'h7E, 8'h19};
    wait_rx(3);
    check_rx();
    wait_idle();

    // Reset in the middle of the data bits of 0x00 with another byte queued
    push_byte(8'h00, e0);
    push_byte(8'h11, e1);
    repeat (8) @(posedge clk_in);
    #2;
    chk_eq("mid_txd_before", 32'(uart_txd), 32'd0);
    sys_rstn = 1'b0;
    #1;
    chk_eq("mid_rst_txd",   32'(uart_txd),       32'd1);
    chk_eq("mid_rst_busy",  32'(tx_busy),        32'd0);
    chk_eq("mid_rst_count", 32'(bus.fifo_count), 32'd0);
    chk_eq("mid_rst_ready", 32'(bus.tx_ready),   32'd1);
    repeat (2) @(negedge clk_in);
    sys_rstn = 1'b1;
    lows = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk_in);
      if (uart_txd == 1'b0 || tx_busy) lows++;
    end
    chk_eq("mid_rst_silent", 32'(lows), 32'd0);
    wait_idle();

    // Loopback bytes through the receiver model
    exp_q = '{8'h00, 8'hFF, 8'h5A};
    for (int i = 0; i < 3; i++) push_byte(exp_q[i], e0);
    wait_rx(3);
    check_rx();
    wait_idle();

    // Randomized bytes with random gaps between pushes
    exp_q.delete();
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom);
      repeat ($urandom_range(0, 50)) @(posedge clk_in);
      #1;
      push_byte(b, e0);
      exp_q.push_back(b);
      chk_eq($sformatf("rand_count_le%0d", i), 32'(bus.fifo_count <= DEPTH), 32'd1);
    end
    wait_rx(16);
    check_rx();
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
